// File: rtl/acc_tile_sequencer.sv
// acc_tile_sequencer: control sequencer for the partial-sum accumulator below the systolic array.
// Latency: write enables are combinational with the accepted beat; drain data follows Acc_Rd_en by 1 cycle.
// Backpressure: comp/ps ready only in their accepting states; drain reads stall while out_valid & !out_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, num_tiles          job request (sampled in IDLE when not busy), main pass count
//   busy, done                job in flight, one-cycle end-of-job pulse
//   comp_valid/comp_ready     compensation beat handshake (INIT)
//   ps_valid/ps_ready         main partial-sum beat handshake (ACCUM)
//   CACC_Wr_en/CAcc_Wr_Addr   accumulator overwrite port
//   ACC_Wr_en/Acc_Wr_Addr     accumulator add-write port
//   Acc_Rd_en/Acc_Rd_Addr     accumulator read port (accumulator registers the data)
//   out_valid/out_last/out_ready  drain handshake for Partial_Sum_out
//
// Optional feature: define ACC_SEQ_OVERLAP_EN to accept first-pass main beats during INIT
// for rows whose compensation value has already been written.
module acc_tile_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int TILE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  input  logic              comp_valid,
  output logic              comp_ready,
  input  logic              ps_valid,
  output logic              ps_ready,
  output logic              CACC_Wr_en,
  output logic [ADDR_W-1:0] CAcc_Wr_Addr,
  output logic              ACC_Wr_en,
  output logic [ADDR_W-1:0] Acc_Wr_Addr,
  output logic              Acc_Rd_en,
  output logic [ADDR_W-1:0] Acc_Rd_Addr,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, INIT, ACCUM, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] comp_row;
  logic [ADDR_W-1:0] ps_row;
  logic [TILE_W-1:0] tile_cnt;
  logic [TILE_W-1:0] tiles_q;
  logic [ADDR_W:0]   rd_cnt;    // one extra bit so it can reach DEPTH (drain complete)

  logic comp_fire;
  logic ps_fire;
  logic ps_last;
  logic out_fire;

  // Readies and the read enable are gated by rst so nothing reaches the
  // accumulator during the reset cycle, even before the state register clears.
  always_comb begin
    comp_ready = 1'b0;
    ps_ready   = 1'b0;
    Acc_Rd_en  = 1'b0;
    if (!rst) begin
      comp_ready = (state == INIT);
`ifdef ACC_SEQ_OVERLAP_EN
      // Rows below comp_row already hold their compensation value, so a
      // first-pass add to them can never hit the row being overwritten.
      ps_ready = (state == ACCUM) || ((state == INIT) && (ps_row < comp_row));
`else
      ps_ready = (state == ACCUM);
`endif
      Acc_Rd_en = (state == DRAIN) && (rd_cnt < DEPTH_CNT) && (!out_valid || out_ready);
    end
  end

  assign comp_fire    = comp_valid & comp_ready;
  assign ps_fire      = ps_valid & ps_ready;
  assign out_fire     = out_valid & out_ready;
  assign ps_last      = (ps_row == LAST_ROW) && (tile_cnt == tiles_q - TILE_W'(1));

  assign CACC_Wr_en   = comp_fire;
  assign CAcc_Wr_Addr = comp_row;
  assign ACC_Wr_en    = ps_fire;
  assign Acc_Wr_Addr  = ps_row;
  assign Acc_Rd_Addr  = rd_cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      comp_row  <= '0;
      ps_row    <= '0;
      tile_cnt  <= '0;
      tiles_q   <= '0;
      rd_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      // busy stays up through the done cycle so a start there is still ignored
      if (done) busy <= 1'b0;

      if (comp_fire) comp_row <= comp_row + ADDR_W'(1);

      if (ps_fire) begin
        if (ps_row == LAST_ROW) begin
          ps_row <= '0;
          if (!ps_last) tile_cnt <= tile_cnt + TILE_W'(1);
        end else begin
          ps_row <= ps_row + ADDR_W'(1);
        end
      end

      // A new read refills the output slot; otherwise an accepted entry empties it.
      if (Acc_Rd_en) begin
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == LAST_CNT);
        rd_cnt    <= rd_cnt + (ADDR_W + 1)'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && !busy) begin
            if (num_tiles != '0) begin
              tiles_q  <= num_tiles;
              comp_row <= '0;
              ps_row   <= '0;
              tile_cnt <= '0;
              rd_cnt   <= '0;
              busy     <= 1'b1;
              state    <= INIT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        INIT: begin
          if (comp_fire && (comp_row == LAST_ROW)) state <= ACCUM;
        end
        ACCUM: begin
          if (ps_fire && ps_last) state <= DRAIN;
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_tile_sequencer.sv
// tb_acc_tile_sequencer: directed bench for acc_tile_sequencer with a behavioural accumulator.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
module tb_acc_tile_sequencer;

`ifdef ACC_SEQ_OVERLAP_EN
  localparam int DONE_T1 = 18;
  localparam int DONE_T2 = 26;
`else
  localparam int DONE_T1 = 25;
  localparam int DONE_T2 = 33;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [3:0] num_tiles;
  logic       busy, done;
  logic       comp_valid, comp_ready;
  logic       ps_valid, ps_ready;
  logic       CACC_Wr_en, ACC_Wr_en, Acc_Rd_en;
  logic [2:0] CAcc_Wr_Addr, Acc_Wr_Addr, Acc_Rd_Addr;
  logic       out_valid, out_last, out_ready;

  logic [15:0] comp_dat, ps_dat, psum_out;
  logic [15:0] mem [0:7];

  int total = 0;
  int bad   = 0;

  // results of the last run_job
  int          r_out_cnt, r_last_at, r_done_cyc;
  int          r_coassert, r_collide, r_addr_err, r_rd_stall, r_stable_err, r_stalls;
  int          r_en_total, r_init_ps, r_lastflag_err;
  logic [15:0] r_out [0:15];
  bit          r_busy0, r_busy_after, r_timeout, r_aborted;

  acc_tile_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_tiles    (num_tiles),
    .busy         (busy),
    .done         (done),
    .comp_valid   (comp_valid),
    .comp_ready   (comp_ready),
    .ps_valid     (ps_valid),
    .ps_ready     (ps_ready),
    .CACC_Wr_en   (CACC_Wr_en),
    .CAcc_Wr_Addr (CAcc_Wr_Addr),
    .ACC_Wr_en    (ACC_Wr_en),
    .Acc_Wr_Addr  (Acc_Wr_Addr),
    .Acc_Rd_en    (Acc_Rd_en),
    .Acc_Rd_Addr  (Acc_Rd_Addr),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready)
  );

  // Accumulator: overwrite port, add port, registered read that holds during stall.
  always @(posedge clk) begin
    if (CACC_Wr_en) mem[CAcc_Wr_Addr] <= comp_dat;
    if (ACC_Wr_en)  mem[Acc_Wr_Addr]  <= mem[Acc_Wr_Addr] + ps_dat;
    if (Acc_Rd_en)  psum_out          <= mem[Acc_Rd_Addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one job. comp beat k carries cbase + k*cinc, every main beat carries psv.
  // gaps: ps_valid low every third cycle. bp: out_ready pattern 1,0,0,1.
  // abort_ps: stop after that many main beats. poke: pulse start mid-ACCUM.
  task automatic run_job(input int nt, input int cbase, input int cinc, input int psv,
                         input bit gaps, input bit bp, input int abort_ps, input bit poke);
    int          comp_seen;
    int          ps_seen;
    bit          stalled;
    logic [15:0] held;
    comp_seen = 0; ps_seen = 0; stalled = 1'b0; held = '0;
    r_out_cnt = 0; r_last_at = -1; r_done_cyc = -1;
    r_coassert = 0; r_collide = 0; r_addr_err = 0; r_rd_stall = 0; r_stable_err = 0;
    r_stalls = 0; r_en_total = 0; r_init_ps = 0; r_lastflag_err = 0;
    r_busy0 = 1'b0; r_busy_after = 1'b1; r_timeout = 1'b1; r_aborted = 1'b0;

    @(negedge clk);
    start = 1'b1; num_tiles = 4'(nt); comp_valid = 1'b0; ps_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start      = poke && (cyc == 12);
      num_tiles  = 4'd5;
      comp_valid = 1'b1;
      ps_valid   = gaps ? (cyc % 3 != 2) : 1'b1;
      out_ready  = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      comp_dat   = 16'(cbase + comp_seen * cinc);
      ps_dat     = 16'(psv);
      #1;
      if (cyc == 0) r_busy0 = busy;
      if (stalled && out_valid) begin
        r_stalls++;
        if (psum_out !== held) r_stable_err++;
      end
      if (Acc_Rd_en && out_valid && !out_ready) r_rd_stall++;
      if (out_last && !out_valid) r_lastflag_err++;
      if (CACC_Wr_en && ACC_Wr_en) begin
        r_coassert++;
        if (CAcc_Wr_Addr == Acc_Wr_Addr) r_collide++;
      end
      if ((CACC_Wr_en !== (comp_valid && comp_ready)) ||
          (CACC_Wr_en && (CAcc_Wr_Addr != 3'(comp_seen)))) r_addr_err++;
      if ((ACC_Wr_en !== (ps_valid && ps_ready)) ||
          (ACC_Wr_en && (Acc_Wr_Addr != 3'(ps_seen)))) r_addr_err++;
      if (comp_ready && ps_ready) r_init_ps++;
      if (CACC_Wr_en || ACC_Wr_en || Acc_Rd_en) r_en_total++;
      if (out_valid && out_ready) begin
        if (r_out_cnt < 16) r_out[r_out_cnt] = psum_out;
        if (out_last) r_last_at = r_out_cnt;
        r_out_cnt++;
      end
      held    = psum_out;
      stalled = out_valid && !out_ready;
      if (comp_valid && comp_ready) comp_seen++;
      if (ps_valid && ps_ready) ps_seen++;
      if (done) begin
        r_done_cyc = cyc;
        r_timeout  = 1'b0;
        @(negedge clk);
        #1;
        r_busy_after = busy;
        break;
      end
      if (abort_ps > 0 && ps_seen == abort_ps) begin
        r_timeout = 1'b0;
        r_aborted = 1'b1;
        break;
      end
    end
    start = 1'b0; comp_valid = 1'b0; ps_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; num_tiles = 4'd2;
    comp_valid = 1'b1; ps_valid = 1'b1; out_ready = 1'b1;
    comp_dat = '0; ps_dat = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    total++;
    if ({comp_ready, ps_ready, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_enables: got %b want 00000",
               {comp_ready, ps_ready, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en});
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; comp_valid = 1'b0; ps_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_serial();
    run_job(2, 10, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    total++; if (r_timeout) begin bad++; $display("FAIL serial_timeout: got no done want done"); end
    total++; if (r_out_cnt != 8) begin bad++; $display("FAIL serial_count: got %0d want 8", r_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'(12 + i)) begin
        bad++; $display("FAIL serial_out%0d: got %0d want %0d", i, r_out[i], 12 + i);
      end
    end
    total++; if (r_last_at != 7) begin bad++; $display("FAIL serial_last: got %0d want 7", r_last_at); end
    total++; if (r_done_cyc != DONE_T2) begin bad++; $display("FAIL serial_done_cycle: got %0d want %0d", r_done_cyc, DONE_T2); end
    total++; if (r_busy0 !== 1'b1) begin bad++; $display("FAIL serial_busy: got %b want 1", r_busy0); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL serial_busy_after: got %b want 0", r_busy_after); end
    total++; if (r_addr_err != 0) begin bad++; $display("FAIL serial_enable_addr: got %0d errors want 0", r_addr_err); end
    total++; if (r_collide != 0) begin bad++; $display("FAIL serial_collision: got %0d want 0", r_collide); end
    total++; if (r_lastflag_err != 0) begin bad++; $display("FAIL serial_last_flag: got %0d want 0", r_lastflag_err); end
  endtask

  task automatic test_backpressure();
    run_job(2, 20, 1, 1, 1'b0, 1'b1, 0, 1'b0);
    total++; if (r_timeout) begin bad++; $display("FAIL bp_timeout: got no done want done"); end
    total++; if (r_out_cnt != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", r_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'(22 + i)) begin
        bad++; $display("FAIL bp_out%0d: got %0d want %0d", i, r_out[i], 22 + i);
      end
    end
    total++; if (r_last_at != 7) begin bad++; $display("FAIL bp_last: got %0d want 7", r_last_at); end
    total++; if (r_stalls == 0) begin bad++; $display("FAIL bp_stalls_seen: got 0 want >0"); end
    total++; if (r_stable_err != 0) begin bad++; $display("FAIL bp_data_stable: got %0d changes want 0", r_stable_err); end
    total++; if (r_rd_stall != 0) begin bad++; $display("FAIL bp_read_in_stall: got %0d want 0", r_rd_stall); end
  endtask

  task automatic test_zero_and_busy_start();
    run_job(0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    total++; if (r_done_cyc != 0) begin bad++; $display("FAIL zero_done_cycle: got %0d want 0", r_done_cyc); end
    total++; if (r_en_total != 0) begin bad++; $display("FAIL zero_enables: got %0d want 0", r_en_total); end
    total++; if (r_out_cnt != 0) begin bad++; $display("FAIL zero_outputs: got %0d want 0", r_out_cnt); end
    run_job(2, 30, 1, 1, 1'b0, 1'b0, 0, 1'b1);
    total++; if (r_out_cnt != 8) begin bad++; $display("FAIL busy_start_count: got %0d want 8", r_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'(32 + i)) begin
        bad++; $display("FAIL busy_start_out%0d: got %0d want %0d", i, r_out[i], 32 + i);
      end
    end
    total++; if (r_done_cyc != DONE_T2) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want %0d", r_done_cyc, DONE_T2); end
  endtask

  task automatic test_reset_mid();
    run_job(3, 50, 1, 1, 1'b0, 1'b0, 5, 1'b0);
    total++; if (!r_aborted) begin bad++; $display("FAIL rstmid_reached: got no abort point want 5 beats"); end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; comp_valid = 1'b1; ps_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if ({comp_ready, ps_ready, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en} !== 5'b0) begin
      bad++;
      $display("FAIL rstmid_enables: got %b want 00000",
               {comp_ready, ps_ready, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en});
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; comp_valid = 1'b0; ps_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if ({busy, done, out_valid} !== 3'b0) begin bad++; $display("FAIL rstmid_state: got %b want 000", {busy, done, out_valid}); end
    run_job(1, 0, 0, 3, 1'b0, 1'b0, 0, 1'b0);
    total++; if (r_out_cnt != 8) begin bad++; $display("FAIL rstmid_count: got %0d want 8", r_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'd3) begin bad++; $display("FAIL rstmid_out%0d: got %0d want 3", i, r_out[i]); end
    end
    total++; if (r_done_cyc != DONE_T1) begin bad++; $display("FAIL rstmid_done_cycle: got %0d want %0d", r_done_cyc, DONE_T1); end
  endtask

  task automatic test_overlap();
    run_job(2, 10, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    total++; if (r_collide != 0) begin bad++; $display("FAIL overlap_collision: got %0d want 0", r_collide); end
`ifdef ACC_SEQ_OVERLAP_EN
    total++; if (r_coassert != 7) begin bad++; $display("FAIL overlap_coassert: got %0d want 7", r_coassert); end
`else
    total++; if (r_coassert != 0) begin bad++; $display("FAIL overlap_coassert: got %0d want 0", r_coassert); end
    total++; if (r_init_ps != 0) begin bad++; $display("FAIL overlap_ps_ready_init: got %0d want 0", r_init_ps); end
`endif
    total++; if (r_done_cyc != DONE_T2) begin bad++; $display("FAIL overlap_done_cycle: got %0d want %0d", r_done_cyc, DONE_T2); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'(12 + i)) begin
        bad++; $display("FAIL overlap_out%0d: got %0d want %0d", i, r_out[i], 12 + i);
      end
    end
  endtask

  task automatic test_stall_accum();
    run_job(15, 10, 1, 2, 1'b1, 1'b0, 0, 1'b0);
    total++; if (r_timeout) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
    total++; if (r_out_cnt != 8) begin bad++; $display("FAIL stall_count: got %0d want 8", r_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_out[i] !== 16'(40 + i)) begin
        bad++; $display("FAIL stall_out%0d: got %0d want %0d", i, r_out[i], 40 + i);
      end
    end
    total++; if (r_last_at != 7) begin bad++; $display("FAIL stall_last: got %0d want 7", r_last_at); end
    total++; if (r_addr_err != 0) begin bad++; $display("FAIL stall_enable_addr: got %0d errors want 0", r_addr_err); end
    total++; if (r_collide != 0) begin bad++; $display("FAIL stall_collision: got %0d want 0", r_collide); end
  endtask

  initial begin
    test_reset();
    test_serial();
    test_backpressure();
    test_zero_and_busy_start();
    test_reset_mid();
    test_overlap();
    test_stall_accum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
